// File: rtl/irq_controller.sv
// irq_controller: prioritised, edge-triggered interrupt controller feeding the
// multicycle control unit. Latches rising edges on irq_in into a pending
// register, masks them, and raises int_sig for the lowest-index eligible
// source. On int_ack it saves the PC into epc and selects the handler vector.
// On int_done it leaves service and re-arms.
module irq_controller #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0080,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_ack,
    input  logic               int_done,
    input  logic [31:0]        pc_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               int_sig,
    output logic [31:0]        vector_addr,
    output logic [31:0]        epc_out,
    output logic               in_service
);

    // Index reported when an acknowledge arrives with nothing eligible
    localparam logic [3:0] SPURIOUS_ID = 4'(NUM_IRQ);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_ack_take;
    logic               w_done_take;

    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_sel_oh;
    logic [NUM_IRQ-1:0] w_clr;
    logic [3:0]         w_sel;

    logic [3:0]         r_active_id;
    logic [31:0]        r_epc;
    logic               r_int_sig;
    logic               w_int_sig_nxt;
    logic [31:0]        w_rdata;
    logic               w_unused_wdata;

    assign w_rise     = irq_in & ~r_irq_prev;
    assign w_eligible = r_pending & r_mask;

    // Service state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: ack only honoured in IDLE, done only honoured in SERVICE
    always_comb begin
        w_state_nxt = r_state;
        w_ack_take  = 1'b0;
        w_done_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (int_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (int_done) begin
                    w_done_take = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Lowest-index eligible source wins; scanning downward leaves the lowest hit
    always_comb begin
        w_sel    = SPURIOUS_ID;
        w_sel_oh = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel       = 4'(i);
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    // Pending clears come from the acknowledged source and from W1C config writes
    always_comb begin
        w_clr = '0;
        if (w_ack_take) begin
            w_clr = w_clr | w_sel_oh;
        end
        if (cfg_we && (cfg_addr == 2'd1)) begin
            w_clr = w_clr | cfg_wdata[NUM_IRQ-1:0];
        end
    end

    // Request is dropped immediately on the accepted ack so the control unit sees one edge
    assign w_int_sig_nxt = (|w_eligible) & (r_state == ST_IDLE) & ~w_ack_take;

    // Edge detector, pending (a same-cycle rise beats any clear) and mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '1;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            if (cfg_we && (cfg_addr == 2'd0)) begin
                r_mask <= cfg_wdata[NUM_IRQ-1:0];
            end
        end
    end

    // Capture return PC and serviced source on an accepted acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_epc       <= '0;
            r_active_id <= '0;
        end else if (w_ack_take) begin
            r_epc       <= pc_in;
            r_active_id <= w_sel;
        end
    end

    // Registered interrupt request to the control unit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_sig <= 1'b0;
        end else begin
            r_int_sig <= w_int_sig_nxt;
        end
    end

    // Config read mux; unused bits read as zero
    always_comb begin
        w_rdata = '0;
        case (cfg_addr)
            2'd0: w_rdata[NUM_IRQ-1:0] = r_mask;
            2'd1: w_rdata[NUM_IRQ-1:0] = r_pending;
            2'd2: begin
                w_rdata[31]  = (r_state == ST_SERVICE);
                w_rdata[3:0] = r_active_id;
            end
            default: w_rdata = r_epc;
        endcase
    end

    // Only the low NUM_IRQ bits of the write data are meaningful
    assign w_unused_wdata = ^cfg_wdata;

    assign cfg_rdata   = w_rdata;
    assign int_sig     = r_int_sig;
    assign in_service  = (r_state == ST_SERVICE);
    assign epc_out     = r_epc;
    assign vector_addr = VEC_BASE + ({28'd0, r_active_id} * VEC_STRIDE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller (NUM_IRQ=4, default vectors).
module tb_irq_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_in;
    logic        int_ack;
    logic        int_done;
    logic [31:0] pc_in;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        int_sig;
    logic [31:0] vector_addr;
    logic [31:0] epc_out;
    logic        in_service;

    int n_cmp = 0;
    int n_err = 0;

    irq_controller #(
        .NUM_IRQ   (4),
        .VEC_BASE  (32'h0000_0080),
        .VEC_STRIDE(32'h0000_0010)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .pc_in      (pc_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .int_sig    (int_sig),
        .vector_addr(vector_addr),
        .epc_out    (epc_out),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs and samples sit 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL rst_int_sig got %0h want 0", int_sig); end
        n_cmp++; if (in_service !== 1'b0) begin n_err++; $display("FAIL rst_in_service got %0h want 0", in_service); end
        n_cmp++; if (vector_addr !== 32'h80) begin n_err++; $display("FAIL rst_vector got %h want 00000080", vector_addr); end
        n_cmp++; if (epc_out !== 32'h0) begin n_err++; $display("FAIL rst_epc got %h want 0", epc_out); end
        cfg_addr = 2'd0; #1;
        n_cmp++; if (cfg_rdata !== 32'hF) begin n_err++; $display("FAIL rst_mask got %h want 0000000f", cfg_rdata); end
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL rst_pending got %h want 0", cfg_rdata); end
        cfg_addr = 2'd2; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL rst_status got %h want 0", cfg_rdata); end
    endtask

    task automatic test_basic();
        irq_in = 4'b0100;
        step();
        irq_in = 4'b0000;
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h4) begin n_err++; $display("FAIL basic_pending got %h want 4", cfg_rdata); end
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL basic_sig_early got %0h want 0", int_sig); end
        step();
        n_cmp++; if (int_sig !== 1'b1) begin n_err++; $display("FAIL basic_sig got %0h want 1", int_sig); end
        int_ack = 1'b1; pc_in = 32'h0000_0124;
        step();
        int_ack = 1'b0;
        n_cmp++; if (epc_out !== 32'h124) begin n_err++; $display("FAIL basic_epc got %h want 124", epc_out); end
        n_cmp++; if (vector_addr !== 32'hA0) begin n_err++; $display("FAIL basic_vector got %h want a0", vector_addr); end
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL basic_sig_ack got %0h want 0", int_sig); end
        n_cmp++; if (in_service !== 1'b1) begin n_err++; $display("FAIL basic_in_service got %0h want 1", in_service); end
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL basic_pending_clr got %h want 0", cfg_rdata); end
        cfg_addr = 2'd2; #1;
        n_cmp++; if (cfg_rdata !== 32'h8000_0002) begin n_err++; $display("FAIL basic_status got %h want 80000002", cfg_rdata); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        n_cmp++; if (in_service !== 1'b0) begin n_err++; $display("FAIL basic_done got %0h want 0", in_service); end
        step();
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL basic_idle_sig got %0h want 0", int_sig); end
    endtask

    task automatic test_priority();
        irq_in = 4'b1010;
        step();
        irq_in = 4'b0000;
        step();
        n_cmp++; if (int_sig !== 1'b1) begin n_err++; $display("FAIL prio_sig got %0h want 1", int_sig); end
        int_ack = 1'b1; pc_in = 32'h0000_0200;
        step();
        int_ack = 1'b0;
        n_cmp++; if (vector_addr !== 32'h90) begin n_err++; $display("FAIL prio_vector1 got %h want 90", vector_addr); end
        cfg_addr = 2'd2; #1;
        n_cmp++; if (cfg_rdata !== 32'h8000_0001) begin n_err++; $display("FAIL prio_status got %h want 80000001", cfg_rdata); end
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h8) begin n_err++; $display("FAIL prio_pending got %h want 8", cfg_rdata); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL prio_sig_done_edge got %0h want 0", int_sig); end
        step();
        n_cmp++; if (int_sig !== 1'b1) begin n_err++; $display("FAIL prio_sig_rearm got %0h want 1", int_sig); end
        // Ack and done together in IDLE: ack wins, done ignored
        int_ack = 1'b1; int_done = 1'b1; pc_in = 32'h0000_0210;
        step();
        int_ack = 1'b0; int_done = 1'b0;
        n_cmp++; if (vector_addr !== 32'hB0) begin n_err++; $display("FAIL prio_vector3 got %h want b0", vector_addr); end
        n_cmp++; if (in_service !== 1'b1) begin n_err++; $display("FAIL prio_ack_done got %0h want 1", in_service); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
    endtask

    task automatic test_mask();
        cfg_write(2'd0, 32'hE);
        cfg_addr = 2'd0; #1;
        n_cmp++; if (cfg_rdata !== 32'hE) begin n_err++; $display("FAIL mask_read got %h want e", cfg_rdata); end
        irq_in = 4'b0001;
        step();
        irq_in = 4'b0000;
        step();
        step();
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h1) begin n_err++; $display("FAIL mask_pending got %h want 1", cfg_rdata); end
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL mask_sig_blocked got %0h want 0", int_sig); end
        cfg_write(2'd0, 32'hF);
        step();
        n_cmp++; if (int_sig !== 1'b1) begin n_err++; $display("FAIL mask_sig_unmask got %0h want 1", int_sig); end
        int_ack = 1'b1; pc_in = 32'h0000_0300;
        step();
        int_ack = 1'b0;
        n_cmp++; if (vector_addr !== 32'h80) begin n_err++; $display("FAIL mask_vector got %h want 80", vector_addr); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
    endtask

    task automatic test_service_block();
        irq_in = 4'b0100;
        step();
        irq_in = 4'b0000;
        step();
        int_ack = 1'b1; pc_in = 32'h0000_0200;
        step();
        int_ack = 1'b0;
        n_cmp++; if (epc_out !== 32'h200) begin n_err++; $display("FAIL svc_epc_first got %h want 200", epc_out); end
        irq_in = 4'b0001; int_ack = 1'b1; pc_in = 32'h0000_DEAD;
        step();
        irq_in = 4'b0000; int_ack = 1'b0;
        n_cmp++; if (epc_out !== 32'h200) begin n_err++; $display("FAIL svc_epc_held got %h want 200", epc_out); end
        n_cmp++; if (vector_addr !== 32'hA0) begin n_err++; $display("FAIL svc_vector_held got %h want a0", vector_addr); end
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h1) begin n_err++; $display("FAIL svc_pending got %h want 1", cfg_rdata); end
        step();
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL svc_sig_blocked got %0h want 0", int_sig); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
        n_cmp++; if (int_sig !== 1'b1) begin n_err++; $display("FAIL svc_sig_after_done got %0h want 1", int_sig); end
        int_ack = 1'b1; pc_in = 32'h0000_0300;
        step();
        int_ack = 1'b0;
        n_cmp++; if (epc_out !== 32'h300) begin n_err++; $display("FAIL svc_epc_second got %h want 300", epc_out); end
        n_cmp++; if (vector_addr !== 32'h80) begin n_err++; $display("FAIL svc_vector_second got %h want 80", vector_addr); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
    endtask

    task automatic test_rise_vs_clear();
        irq_in = 4'b0010;
        step();
        irq_in = 4'b0000;
        step();
        irq_in = 4'b0010; int_ack = 1'b1; pc_in = 32'h0000_0400;
        step();
        irq_in = 4'b0000; int_ack = 1'b0;
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h2) begin n_err++; $display("FAIL race_pending got %h want 2", cfg_rdata); end
        cfg_addr = 2'd2; #1;
        n_cmp++; if (cfg_rdata !== 32'h8000_0001) begin n_err++; $display("FAIL race_status got %h want 80000001", cfg_rdata); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
        n_cmp++; if (int_sig !== 1'b1) begin n_err++; $display("FAIL race_sig_rearm got %0h want 1", int_sig); end
        int_ack = 1'b1; pc_in = 32'h0000_0410;
        step();
        int_ack = 1'b0;
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL race_pending_clr got %h want 0", cfg_rdata); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
    endtask

    task automatic test_cfg_access();
        irq_in = 4'b1000;
        step();
        irq_in = 4'b0000;
        cfg_write(2'd1, 32'h8);
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL w1c_pending got %h want 0", cfg_rdata); end
        step();
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL w1c_sig got %0h want 0", int_sig); end
        cfg_write(2'd3, 32'h1234);
        cfg_write(2'd2, 32'hFFFF_FFFF);
        cfg_addr = 2'd3; #1;
        n_cmp++; if (cfg_rdata !== 32'h410) begin n_err++; $display("FAIL ro_epc got %h want 410", cfg_rdata); end
        cfg_addr = 2'd2; #1;
        n_cmp++; if (cfg_rdata !== 32'h1) begin n_err++; $display("FAIL ro_status got %h want 1", cfg_rdata); end
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        n_cmp++; if (in_service !== 1'b0) begin n_err++; $display("FAIL idle_done got %0h want 0", in_service); end
    endtask

    task automatic test_level_spurious_reset();
        irq_in = 4'b0010;
        for (int i = 0; i < 10; i++) step();
        n_cmp++; if (int_sig !== 1'b1) begin n_err++; $display("FAIL level_sig got %0h want 1", int_sig); end
        int_ack = 1'b1; pc_in = 32'h0000_0500;
        step();
        int_ack = 1'b0;
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
        step();
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL level_no_repend got %0h want 0", int_sig); end
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL level_pending got %h want 0", cfg_rdata); end
        irq_in = 4'b0000;
        step();
        int_ack = 1'b1; pc_in = 32'h0000_0600;
        step();
        int_ack = 1'b0;
        n_cmp++; if (vector_addr !== 32'hC0) begin n_err++; $display("FAIL spur_vector got %h want c0", vector_addr); end
        n_cmp++; if (epc_out !== 32'h600) begin n_err++; $display("FAIL spur_epc got %h want 600", epc_out); end
        cfg_addr = 2'd2; #1;
        n_cmp++; if (cfg_rdata !== 32'h8000_0004) begin n_err++; $display("FAIL spur_status got %h want 80000004", cfg_rdata); end
        cfg_write(2'd0, 32'h5);
        irq_in = 4'b0001;
        step();
        irq_in = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (in_service !== 1'b0) begin n_err++; $display("FAIL mrst_in_service got %0h want 0", in_service); end
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL mrst_sig got %0h want 0", int_sig); end
        n_cmp++; if (vector_addr !== 32'h80) begin n_err++; $display("FAIL mrst_vector got %h want 80", vector_addr); end
        n_cmp++; if (epc_out !== 32'h0) begin n_err++; $display("FAIL mrst_epc got %h want 0", epc_out); end
        cfg_addr = 2'd0; #1;
        n_cmp++; if (cfg_rdata !== 32'hF) begin n_err++; $display("FAIL mrst_mask got %h want f", cfg_rdata); end
        cfg_addr = 2'd1; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL mrst_pending got %h want 0", cfg_rdata); end
        step();
        n_cmp++; if (int_sig !== 1'b0) begin n_err++; $display("FAIL mrst_sig_later got %0h want 0", int_sig); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        irq_in    = '0;
        int_ack   = 1'b0;
        int_done  = 1'b0;
        pc_in     = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_service_block();
        test_rise_vs_clear();
        test_cfg_access();
        test_level_spurious_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller sitting directly upstream of the multicycle control unit.
- Collects NUM_IRQ external request lines, detects rising edges, applies a mask, and drives the single int_sig request into the control FSM.
- On the control unit's int_save_pc acknowledge it captures the return PC (EPC), enters in-service state and presents the vector address to the PC source mux.
- On RFE completion it leaves service and re-arms.

Parameters:
NUM_IRQ, 4, number of interrupt source lines (1..8)
VEC_BASE, 32'h0000_0080, vector address of source 0
VEC_STRIDE, 32'h0000_0010, byte spacing between consecutive source vectors

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
irq_in  input  NUM_IRQ  raw request lines; rising edge requests service
int_ack  input  1  from control unit int_save_pc; one-cycle acknowledge
int_done  input  1  one-cycle pulse when RFE writes PC (end of handler)
pc_in  input  32  current PC value, captured on int_ack
cfg_we  input  1  config register write enable
cfg_addr  input  2  config register select
cfg_wdata  input  32  config write data
cfg_rdata  output  32  config read data (combinational on cfg_addr)
int_sig  output  1  interrupt request to control unit (level)
vector_addr  output  32  handler address for PC source 'b11
epc_out  output  32  saved PC for PC source 'b100
in_service  output  1  handler currently executing

Behaviour:
- All state updates on posedge clk; rst synchronous, highest priority over all other events.
- Reset values:
  - pending=0, irq_prev=0, mask=all ones (enabled).
  - in_service=0, active_id=0, epc=0.
  - int_sig=0, vector_addr=VEC_BASE, cfg_rdata reflects reset registers.
- Edge detect: irq_prev<=irq_in each cycle. rise=irq_in & ~irq_prev sets the corresponding pending bit. A level held high does not re-pend.
- eligible = pending & mask. Priority: lowest index wins; sel = index of lowest set eligible bit.
- int_sig = |eligible & ~in_service, registered (asserted the cycle after the pending bit sets). It stays high until int_ack; control unit sees one rising edge per request.
- States: IDLE (in_service=0), SERVICE (in_service=1).
  - IDLE -> SERVICE on int_ack: epc<=pc_in, active_id<=sel, pending[sel]<=0, in_service<=1.
  - SERVICE -> IDLE on int_done: in_service<=0. Remaining eligible bits re-raise int_sig the next cycle.
- vector_addr = VEC_BASE + active_id*VEC_STRIDE (32-bit, wraps modulo 2^32). Valid from the cycle after int_ack.
- Boundary conditions:
  - int_ack with eligible=0 (spurious): still enter SERVICE and capture epc, with active_id=NUM_IRQ (spurious vector). No pending bit cleared.
  - int_ack while in_service=1: ignored; epc and active_id held.
  - Same-cycle rise and ack-clear on the same bit: set wins, bit stays pending.
  - Same-cycle int_ack and int_done in IDLE: ack processed, done ignored.
  - int_done in IDLE: no effect.
  - Masking a bit clears it from eligible but not from pending; unmasking re-raises int_sig if pending.
  - Reset mid-service: all state returns to reset values; the in-flight request is lost.
- Config map:
  - addr 0: mask[NUM_IRQ-1:0], read/write.
  - addr 1: pending, read; write-1-to-clear. A rise on that bit in the same cycle wins.
  - addr 2: status {in_service at bit 31, active_id at bits 3:0}, read-only.
  - addr 3: epc, read-only.
  - Unused bits read 0. Writes to read-only addresses are ignored.

Test Plan:
- Reset, then pulse irq_in[2] for 1 cycle -> pending=4'b0100, int_sig=1 next cycle. int_ack with pc_in=32'h0000_0124 -> epc_out=32'h124, vector_addr=32'h0000_00A0, int_sig=0, in_service=1, pending=0.
- irq_in[3] and irq_in[1] rise together, int_ack -> active_id=1, vector_addr=32'h90, pending=4'b1000. int_done -> int_sig=1 again. Second ack -> vector_addr=32'hB0.
- Write mask=4'b1110, pulse irq_in[0] -> pending[0]=1, int_sig=0. Write mask=4'b1111 -> int_sig=1 next cycle.
- In SERVICE, pulse irq_in[0] and int_ack with pc_in=32'hDEAD -> epc unchanged, pending[0]=1, int_sig stays 0 until int_done.
- Hold irq_in[1] high 10 cycles, ack once, int_done -> no second request. int_ack with nothing pending -> active_id=4, vector_addr=32'hC0. Assert rst mid-service -> all outputs return to reset values.
